fadd_seq_ctrl: RTL and testbench



---
 rtl/fadd_pkg.sv | 26 ++
 rtl/fadd_seq_ctrl_if.sv | 21 ++
 rtl/fadd_norm_step.sv | 44 ++++
 rtl/fadd_seq_ctrl.sv | 133 +++++++++++++
 tb/tb_fadd_seq_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/fadd_pkg.sv
// Shared types and constants for the sequential single-precision adder.
package fadd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } state_t;

  localparam int MANT_W    = 24;
  localparam int SUM_W     = 25;
  localparam int EXP_W     = 8;
  localparam int EXP_INT_W = 10;

  localparam logic [31:0]      FP_POS_ZERO         = 32'h0000_0000;
  localparam logic [EXP_W-1:0] FP_INF_EXP          = 8'hFF;
  localparam int               ALIGN_LIMIT_DEFAULT = 25;

  // Denormals are flushed: a zero exponent yields a zero mantissa.
  function automatic logic [MANT_W-1:0] unpack_mant(input logic [31:0] f);
    return (f[30:23] == 8'd0) ? '0 : {1'b1, f[22:0]};
  endfunction

endpackage

// File: rtl/fadd_seq_ctrl_if.sv
// Operand and result handshakes between issue logic and the adder sequencer.
interface fadd_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        op_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  modport master (
    output in_valid, a, b, op_sub, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, a, b, op_sub, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/fadd_norm_step.sv
// One normalize decision per cycle: zero/underflow/overflow detection,
// single-bit shift of the sum, or final packing.
module fadd_norm_step
  import fadd_pkg::*;
(
  input  logic                        sign,
  input  logic [SUM_W-1:0]            sum,
  input  logic signed [EXP_INT_W-1:0] exp_in,
  output logic                        done,
  output logic [31:0]                 pack_res,
  output logic [SUM_W-1:0]            sum_nxt,
  output logic signed [EXP_INT_W-1:0] exp_nxt
);

  localparam logic signed [EXP_INT_W-1:0] EXP_ZERO = '0;
  localparam logic signed [EXP_INT_W-1:0] EXP_ONE  = EXP_INT_W'(1);
  localparam logic signed [EXP_INT_W-1:0] EXP_MAX  = EXP_INT_W'(255);

  always_comb begin
    done     = 1'b0;
    pack_res = FP_POS_ZERO;
    sum_nxt  = sum;
    exp_nxt  = exp_in;
    if (sum == '0) begin
      done = 1'b1;
    end else if (exp_in <= EXP_ZERO) begin
      done     = 1'b1;
      pack_res = {sign, 31'd0};
    end else if (sum[SUM_W-1]) begin
      sum_nxt = sum >> 1;
      exp_nxt = exp_in + EXP_ONE;
    end else if (!sum[MANT_W-1]) begin
      sum_nxt = sum << 1;
      exp_nxt = exp_in - EXP_ONE;
    end else begin
      done = 1'b1;
      if (exp_in >= EXP_MAX)
        pack_res = {sign, FP_INF_EXP, 23'd0};
      else
        pack_res = {sign, exp_in[EXP_W-1:0], sum[MANT_W-2:0]};
    end
  end

endmodule

// File: rtl/fadd_seq_ctrl.sv
// Multi-cycle IEEE single add/sub sequencer around one shared 25-bit add step.
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   ALIGN | shift smaller mantissa right one bit per cycle until cnt is 0
//   ADD   | single mantissa add or subtract
//   NORM  | one normalize shift per cycle, then pack
//   DONE  | result held with out_valid until out_ready
module fadd_seq_ctrl
  import fadd_pkg::*;
#(
  parameter int ALIGN_LIMIT = ALIGN_LIMIT_DEFAULT,
  parameter bit SUB_EN      = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  fadd_seq_ctrl_if.slave  bus,
  output logic            busy
);

  state_t                        state;
  logic                          rdy_q;
  logic                          out_valid_q;
  logic [31:0]                   result_q;
  logic                          busy_q;
  logic [EXP_W-1:0]              cnt;
  logic [MANT_W-1:0]             m_a, m_b;
  logic                          sgn_a, sgn_b;
  logic signed [EXP_INT_W-1:0]   exp_r;
  logic [SUM_W-1:0]              sum;

  logic                          sa_in, sb_in, swap, far;
  logic [EXP_W-1:0]              ea_in, eb_in, e_big, diff;
  logic [MANT_W-1:0]             ma_in, mb_in;

  logic                          ns_done;
  logic [31:0]                   ns_res;
  logic [SUM_W-1:0]              ns_sum;
  logic signed [EXP_INT_W-1:0]   ns_exp;

  assign ea_in = bus.a[30:23];
  assign eb_in = bus.b[30:23];
  assign ma_in = unpack_mant(bus.a);
  assign mb_in = unpack_mant(bus.b);
  assign sa_in = bus.a[31];
  assign sb_in = bus.b[31] ^ (SUB_EN & bus.op_sub);

  // Larger magnitude always lands in the A slot so the subtract never goes negative.
  assign swap  = (eb_in > ea_in) || ((eb_in == ea_in) && (mb_in > ma_in));
  assign e_big = swap ? eb_in : ea_in;
  assign diff  = swap ? (eb_in - ea_in) : (ea_in - eb_in);
  assign far   = int'(diff) >= ALIGN_LIMIT;

  fadd_norm_step u_norm (
    .sign     (sgn_a),
    .sum      (sum),
    .exp_in   (exp_r),
    .done     (ns_done),
    .pack_res (ns_res),
    .sum_nxt  (ns_sum),
    .exp_nxt  (ns_exp)
  );

  assign bus.in_ready  = rdy_q & ~rst;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign busy          = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rdy_q       <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= FP_POS_ZERO;
      busy_q      <= 1'b0;
      cnt         <= '0;
      m_a         <= '0;
      m_b         <= '0;
      sgn_a       <= 1'b0;
      sgn_b       <= 1'b0;
      exp_r       <= '0;
      sum         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && rdy_q) begin
            m_a    <= swap ? mb_in : ma_in;
            m_b    <= far ? '0 : (swap ? ma_in : mb_in);
            sgn_a  <= swap ? sb_in : sa_in;
            sgn_b  <= swap ? sa_in : sb_in;
            exp_r  <= $signed({2'b00, e_big});
            cnt    <= far ? '0 : diff;
            rdy_q  <= 1'b0;
            busy_q <= 1'b1;
            state  <= ALIGN;
          end
        end
        ALIGN: begin
          if (cnt == '0) begin
            state <= ADD;
          end else begin
            m_b <= m_b >> 1;
            cnt <= cnt - 1'b1;
          end
        end
        ADD: begin
          sum   <= (sgn_a == sgn_b) ? ({1'b0, m_a} + {1'b0, m_b})
                                    : ({1'b0, m_a} - {1'b0, m_b});
          state <= NORM;
        end
        NORM: begin
          if (ns_done) begin
            result_q    <= ns_res;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            sum   <= ns_sum;
            exp_r <= ns_exp;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            rdy_q       <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fadd_seq_ctrl.sv
// Directed and random checks of fadd_seq_ctrl against an arithmetic reference model.
module tb_fadd_seq_ctrl;
  import fadd_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   errors = 0;
  int   checks = 0;

  fadd_seq_ctrl_if bus();

  fadd_seq_ctrl #(.ALIGN_LIMIT(25), .SUB_EN(1'b1)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: truncating single-precision add with flush-to-zero, plus cycle count.
  task automatic model(input logic [31:0] av, input logic [31:0] bv, input bit sub,
                       output logic [31:0] res, output int lat);
    int ea, eb, ma, mb, t, d, s, p, k, e, mnt;
    bit sa, sb, tb;
    ea = int'(av[30:23]);
    eb = int'(bv[30:23]);
    ma = (ea == 0) ? 0 : (int'(av[22:0]) + (1 << 23));
    mb = (eb == 0) ? 0 : (int'(bv[22:0]) + (1 << 23));
    sa = av[31];
    sb = bv[31] ^ sub;
    if (eb > ea || (eb == ea && mb > ma)) begin
      t = ea; ea = eb; eb = t;
      t = ma; ma = mb; mb = t;
      tb = sa; sa = sb; sb = tb;
    end
    d = ea - eb;
    if (d >= 25) begin
      mb = 0;
      d  = 0;
    end else begin
      mb = mb / (1 << d);
    end
    s   = (sa == sb) ? ma + mb : ma - mb;
    lat = 3 + d;
    if (s == 0) begin
      res = 32'h0;
      return;
    end
    p = 0;
    for (int i = 0; i < 25; i++)
      if (s >= (1 << i)) p = i;
    if (p == 24) begin
      lat += 1;
      e   = ea + 1;
      mnt = s / 2;
    end else begin
      k = 23 - p;
      if (ea - k <= 0) begin
        lat += ea;
        res = {sa, 31'd0};
        return;
      end
      lat += k;
      e   = ea - k;
      mnt = s * (1 << k);
    end
    if (e >= 255) res = {sa, 8'hFF, 23'd0};
    else          res = {sa, e[7:0], mnt[22:0]};
  endtask

  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input bit sub,
                        input string tag, input int hold);
    logic [31:0] er;
    logic [31:0] held;
    int          el, lat;
    model(av, bv, sub, er, el);
    bus.a        = av;
    bus.b        = bv;
    bus.op_sub   = sub;
    bus.in_valid = 1'b1;
    chk({tag, " in_ready idle"}, {31'd0, bus.in_ready}, 32'd1);
    tick;
    bus.in_valid = 1'b0;
    chk({tag, " busy after accept"}, {31'd0, busy}, 32'd1);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      tick;
      lat++;
    end
    chk({tag, " latency"}, lat, el);
    chk({tag, " result"}, bus.result, er);
    chk({tag, " ready/valid exclusive"}, {31'd0, bus.in_ready & bus.out_valid}, 32'd0);
    held = bus.result;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      tick;
      chk({tag, " held result"}, bus.result, held);
      chk({tag, " held out_valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({tag, " held in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk({tag, " out_valid drop"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, " back to idle"}, {31'd0, busy}, 32'd0);
    chk({tag, " in_ready return"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          ea, eb;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op_sub    = 1'b0;
    bus.out_ready = 1'b0;

    tick;
    tick;
    chk("reset in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset result", bus.result, 32'h0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post-reset in_ready", {31'd0, bus.in_ready}, 32'd1);

    run_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, "one_plus_one", 0);
    run_op(32'h4040_0000, 32'h3F80_0000, 1'b1, "three_minus_one", 0);
    run_op(32'h3F80_0000, 32'hBF80_0000, 1'b0, "cancel_to_zero", 0);
    run_op(32'h4B80_0000, 32'h3F80_0000, 1'b0, "diff24_shift", 0);
    run_op(32'h3F80_0000, 32'h3300_0000, 1'b0, "diff25_forced", 0);
    run_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, "overflow_inf", 0);
    run_op(32'h3F80_0000, 32'h4040_0000, 1'b1, "neg_result", 0);
    run_op(32'h0080_0001, 32'h0080_0000, 1'b1, "underflow", 0);
    run_op(32'h4120_0000, 32'h3F00_0000, 1'b0, "backpressure", 10);

    // Abort an operation mid-alignment with ten shifts still pending.
    bus.a        = 32'h4480_0000;
    bus.b        = 32'h3F80_0000;
    bus.op_sub   = 1'b0;
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    chk("abort busy before rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("abort in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("abort out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort result", bus.result, 32'h0);
    tick;
    chk("abort stays idle", {31'd0, busy}, 32'd0);
    run_op(32'h4480_0000, 32'h3F80_0000, 1'b0, "after_abort", 0);

    for (int n = 0; n < 40; n++) begin
      ea = (($urandom & 7) == 0) ? 0 : int'($urandom_range(1, 254));
      eb = ea - int'($urandom_range(0, 30));
      if (eb < 0) eb = 0;
      ra = {$urandom_range(0, 1) == 1, ea[7:0], 23'($urandom)};
      rb = {$urandom_range(0, 1) == 1, eb[7:0], 23'($urandom)};
      if (($urandom & 3) == 0) rb[22:8] = ra[22:8];
      if ($urandom_range(0, 1) == 1)
        run_op(rb, ra, $urandom_range(0, 1) == 1, "random", 0);
      else
        run_op(ra, rb, $urandom_range(0, 1) == 1, "random", 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
